// File: rtl/exec_step_ctrl.sv
// Execution controller: turns board keys/switches into a one-cycle core clock
// enable with run, pause, single-step, halt and one instruction breakpoint.

module exec_step_key_det (
  input  logic clock,
  input  logic reset,
  input  logic key_n,
  output logic press_c
);

  logic sync1;
  logic sync2;
  logic prev;

  // Two-flop synchronizer plus a history flop for falling-edge detection
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      prev  <= 1'b1;
    end else begin
      sync1 <= key_n;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign press_c = prev & ~sync2;

endmodule

module exec_step_ctrl #(
  parameter int unsigned DIV_COUNT = 25000000,
  parameter int unsigned CNT_W     = 25
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        run_n,
  input  logic        step_n,
  input  logic        halt,
  input  logic        bp_enable,
  input  logic [31:0] bp_addr,
  input  logic [31:0] pc,
  output logic        cpu_en,
  output logic [1:0]  state,
  output logic        bp_hit,
  output logic [31:0] step_count
);

  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned COUNT_W = 32;

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_RUN   = 2'b01;
  localparam logic [1:0] ST_STEP  = 2'b10;
  localparam logic [1:0] ST_BREAK = 2'b11;

  logic               run_press_c;
  logic               step_press_c;
  logic               bp_match_c;
  logic               tick_c;

  logic [CNT_W-1:0]   prescale_q;
  logic [CNT_W-1:0]   prescale_next;
  logic               skip_q;
  logic               skip_next;
  logic [1:0]         state_next;
  logic               cpu_en_next;
  logic               bp_hit_next;
  logic [COUNT_W-1:0] step_count_next;

  exec_step_key_det u_run_det (
    .clock   (clock),
    .reset   (reset),
    .key_n   (run_n),
    .press_c (run_press_c)
  );

  exec_step_key_det u_step_det (
    .clock   (clock),
    .reset   (reset),
    .key_n   (step_n),
    .press_c (step_press_c)
  );

  assign bp_match_c = bp_enable & (pc == ADDR_W'(bp_addr));
  assign tick_c     = (prescale_q == CNT_W'(DIV_COUNT - 1));

  // State and all registered outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= ST_IDLE;
      cpu_en     <= 1'b0;
      bp_hit     <= 1'b0;
      step_count <= '0;
      prescale_q <= '0;
      skip_q     <= 1'b0;
    end else begin
      state      <= state_next;
      cpu_en     <= cpu_en_next;
      bp_hit     <= bp_hit_next;
      step_count <= step_count_next;
      prescale_q <= prescale_next;
      skip_q     <= skip_next;
    end
  end

  // Next-state and output decode; halt overrides every key press
  always_comb begin
    state_next  = state;
    skip_next   = skip_q;
    cpu_en_next = 1'b0;

    if (halt) begin
      state_next = ST_IDLE;
      skip_next  = 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (run_press_c) begin
            state_next = ST_RUN;
          end else if (step_press_c) begin
            state_next = ST_STEP;
          end
        end
        ST_RUN: begin
          if (run_press_c) begin
            state_next = ST_IDLE;
          end else if (tick_c) begin
            if (bp_match_c && !skip_q) begin
              state_next = ST_BREAK;
            end else begin
              cpu_en_next = 1'b1;
              skip_next   = 1'b0;
            end
          end
        end
        ST_STEP: begin
          cpu_en_next = 1'b1;
          state_next  = ST_IDLE;
        end
        ST_BREAK: begin
          // skip lets the breakpointed instruction execute once on resume
          if (run_press_c) begin
            state_next = ST_RUN;
            skip_next  = 1'b1;
          end else if (step_press_c) begin
            state_next = ST_STEP;
          end
        end
      endcase
    end

    bp_hit_next     = (state_next == ST_BREAK);
    step_count_next = step_count + COUNT_W'(cpu_en_next);

    if (state == ST_RUN) begin
      prescale_next = tick_c ? '0 : prescale_q + CNT_W'(1);
    end else begin
      prescale_next = '0;
    end
  end

endmodule

// File: tb/tb_exec_step_ctrl.sv
// Bench for exec_step_ctrl: directed scenarios plus random key/halt/reset
// traffic, every cycle compared against a behavioural model.

module tb_exec_step_ctrl;

  localparam int unsigned DIV   = 4;
  localparam int unsigned CNT_W = 3;

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_STEP  = 2;
  localparam int M_BREAK = 3;

  logic        clock = 1'b0;
  logic        reset;
  logic        run_n;
  logic        step_n;
  logic        halt;
  logic        bp_enable;
  logic [31:0] bp_addr;
  logic [31:0] pc;
  logic        cpu_en;
  logic [1:0]  state;
  logic        bp_hit;
  logic [31:0] step_count;

  exec_step_ctrl #(
    .DIV_COUNT (DIV),
    .CNT_W     (CNT_W)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .run_n      (run_n),
    .step_n     (step_n),
    .halt       (halt),
    .bp_enable  (bp_enable),
    .bp_addr    (bp_addr),
    .pc         (pc),
    .cpu_en     (cpu_en),
    .state      (state),
    .bp_hit     (bp_hit),
    .step_count (step_count)
  );

  always #5 clock = ~clock;

  int tests_run    = 0;
  int tests_failed = 0;
  int en_seen      = 0;

  // Reference model: mode, cycles spent in RUN, skip flag, outputs
  int          m_state = M_IDLE;
  int          m_phase = 0;
  bit          m_skip  = 1'b0;
  bit          m_en    = 1'b0;
  bit          m_bp_hit = 1'b0;
  logic [31:0] m_count = 32'h0;
  bit          run_hist[$];
  bit          step_hist[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Pin history: a press is seen three edges after the pin is first sampled low
  task automatic model_edge();
    bit pr;
    bit ps;
    bit bpm;
    bit tick;
    int nxt;
    if (reset) begin
      m_state  = M_IDLE;
      m_phase  = 0;
      m_skip   = 1'b0;
      m_en     = 1'b0;
      m_bp_hit = 1'b0;
      m_count  = 32'h0;
      run_hist.delete();
      step_hist.delete();
      repeat (3) begin
        run_hist.push_back(1'b1);
        step_hist.push_back(1'b1);
      end
      return;
    end
    pr = run_hist[0] && !run_hist[1];
    ps = step_hist[0] && !step_hist[1];
    void'(run_hist.pop_front());
    void'(step_hist.pop_front());
    run_hist.push_back(run_n);
    step_hist.push_back(step_n);
    bpm  = bp_enable && (pc == bp_addr);
    tick = (m_phase == int'(DIV) - 1);
    nxt  = m_state;
    m_en = 1'b0;
    if (halt) begin
      nxt    = M_IDLE;
      m_skip = 1'b0;
    end else if (m_state == M_IDLE) begin
      if (pr) nxt = M_RUN;
      else if (ps) nxt = M_STEP;
    end else if (m_state == M_RUN) begin
      if (pr) nxt = M_IDLE;
      else if (tick && bpm && !m_skip) nxt = M_BREAK;
      else if (tick) begin
        m_en   = 1'b1;
        m_skip = 1'b0;
      end
    end else if (m_state == M_STEP) begin
      m_en = 1'b1;
      nxt  = M_IDLE;
    end else begin
      if (pr) begin
        nxt    = M_RUN;
        m_skip = 1'b1;
      end else if (ps) nxt = M_STEP;
    end
    m_phase  = (m_state == M_RUN) ? (m_phase + 1) % int'(DIV) : 0;
    m_state  = nxt;
    m_bp_hit = (nxt == M_BREAK);
    if (m_en) m_count = m_count + 32'd1;
  endtask

  task automatic cyc();
    @(posedge clock);
    model_edge();
    @(negedge clock);
    check("state", 32'(state), 32'(m_state));
    check("cpu_en", 32'(cpu_en), 32'(m_en));
    check("bp_hit", 32'(bp_hit), 32'(m_bp_hit));
    check("step_count", step_count, m_count);
    if (cpu_en) en_seen++;
  endtask

  task automatic wait_state(input int target, input int max_cycles, input string tag);
    for (int i = 0; i < max_cycles && int'(state) != target; i++) cyc();
    check(tag, 32'(state), 32'(target));
  endtask

  initial begin
    int run_left;
    int step_left;
    int halt_left;
    reset = 1'b1; run_n = 1'b1; step_n = 1'b1; halt = 1'b0;
    bp_enable = 1'b0; bp_addr = 32'h0; pc = 32'h0;
    repeat (3) cyc();
    check("rst_state", 32'(state), 32'd0);
    check("rst_cpu_en", 32'(cpu_en), 32'd0);
    check("rst_step_count", step_count, 32'd0);
    reset = 1'b0;
    repeat (2) cyc();

    // Free run: first enable four cycles after entry, then every fourth
    run_n = 1'b0;
    wait_state(M_RUN, 10, "t1_run_entry");
    en_seen = 0;
    repeat (2) cyc();
    run_n = 1'b1;
    repeat (34) cyc();
    check("t1_step_count", step_count, 32'd9);
    check("t1_pulses", 32'(en_seen), 32'd9);
    run_n = 1'b0; cyc(); run_n = 1'b1;
    wait_state(M_IDLE, 10, "t1_pause");
    repeat (4) cyc();

    // Single steps, then a long hold that must give only one step
    en_seen = 0;
    for (int i = 0; i < 3; i++) begin
      step_n = 1'b0; repeat (2) cyc(); step_n = 1'b1;
      repeat (6) cyc();
      check("t2_back_idle", 32'(state), 32'd0);
    end
    check("t2_pulses", 32'(en_seen), 32'd3);
    en_seen = 0;
    step_n = 1'b0; repeat (20) cyc(); step_n = 1'b1;
    repeat (6) cyc();
    check("t2_hold_pulses", 32'(en_seen), 32'd1);

    // Breakpoint, resume past it once, break again
    bp_enable = 1'b1; bp_addr = 32'h10; pc = 32'h10;
    en_seen = 0;
    run_n = 1'b0;
    wait_state(M_RUN, 10, "t3_run");
    run_n = 1'b1;
    wait_state(M_BREAK, 20, "t3_break");
    check("t3_bp_hit", 32'(bp_hit), 32'd1);
    check("t3_no_en", 32'(en_seen), 32'd0);
    en_seen = 0;
    run_n = 1'b0;
    wait_state(M_RUN, 10, "t3_resume");
    run_n = 1'b1;
    wait_state(M_BREAK, 20, "t3_rebreak");
    check("t3_one_en", 32'(en_seen), 32'd1);

    // Halt from BREAK, keys ignored while halted
    halt = 1'b1;
    run_n = 1'b0; step_n = 1'b0; repeat (2) cyc(); run_n = 1'b1; step_n = 1'b1;
    repeat (8) cyc();
    check("t4_brk_halt_state", 32'(state), 32'd0);
    check("t4_brk_halt_bp", 32'(bp_hit), 32'd0);
    halt = 1'b0;
    repeat (10) cyc();
    check("t4_brk_stay_idle", 32'(state), 32'd0);
    // Halt from RUN
    bp_enable = 1'b0;
    run_n = 1'b0;
    wait_state(M_RUN, 10, "t4_run");
    run_n = 1'b1;
    repeat (3) cyc();
    halt = 1'b1;
    repeat (2) cyc();
    step_n = 1'b0; repeat (2) cyc(); step_n = 1'b1;
    repeat (8) cyc();
    check("t4_run_halt_state", 32'(state), 32'd0);
    check("t4_run_halt_en", 32'(cpu_en), 32'd0);
    halt = 1'b0;
    repeat (10) cyc();
    check("t4_run_stay_idle", 32'(state), 32'd0);

    // Simultaneous presses pick RUN; run press on the tick cycle pauses cleanly
    run_n = 1'b0; step_n = 1'b0;
    wait_state(M_RUN, 10, "t5_both_run");
    run_n = 1'b1; step_n = 1'b1;
    for (int i = 0; i < 20 && m_phase != 1; i++) cyc();
    en_seen = 0;
    run_n = 1'b0; repeat (2) cyc(); run_n = 1'b1;
    repeat (5) cyc();
    check("t5_tick_idle", 32'(state), 32'd0);
    check("t5_tick_no_en", 32'(en_seen), 32'd0);

    // Step counter wrap, then reset landing on STEP entry
    repeat (4) cyc();
    force dut.step_count = 32'hFFFF_FFFF;
    m_count = 32'hFFFF_FFFF;
    cyc();
    release dut.step_count;
    check("t6_preload", step_count, 32'hFFFF_FFFF);
    step_n = 1'b0; cyc(); step_n = 1'b1;
    repeat (6) cyc();
    check("t6_wrap", step_count, 32'h0);
    step_n = 1'b0;
    wait_state(M_STEP, 10, "t6_step_entry");
    step_n = 1'b1; reset = 1'b1;
    cyc();
    reset = 1'b0;
    check("t6_rst_cpu_en", 32'(cpu_en), 32'd0);
    check("t6_rst_state", 32'(state), 32'd0);
    check("t6_rst_bp_hit", 32'(bp_hit), 32'd0);
    check("t6_rst_count", step_count, 32'd0);
    repeat (3) cyc();

    // Random traffic against the model
    run_left = 0; step_left = 0; halt_left = 0;
    for (int i = 0; i < 3000; i++) begin
      if (run_left > 0) begin run_n = 1'b0; run_left--; end
      else begin
        run_n = 1'b1;
        if ($urandom_range(11, 0) == 0) run_left = int'($urandom_range(6, 1));
      end
      if (step_left > 0) begin step_n = 1'b0; step_left--; end
      else begin
        step_n = 1'b1;
        if ($urandom_range(9, 0) == 0) step_left = int'($urandom_range(6, 1));
      end
      if (halt_left > 0) begin halt = 1'b1; halt_left--; end
      else begin
        halt = 1'b0;
        if ($urandom_range(59, 0) == 0) halt_left = int'($urandom_range(15, 3));
      end
      reset = ($urandom_range(399, 0) == 0);
      if ($urandom_range(29, 0) == 0) bp_enable = ~bp_enable;
      pc = ($urandom_range(2, 0) == 0) ? bp_addr : 32'($urandom_range(31, 0));
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, tests_run=%0d", tests_run);
    $fatal(1);
  end

endmodule

// File: doc/exec_step_ctrl.md
Name: exec_step_ctrl

Overview:
- Execution controller for the processor core: produces a one-cycle clock-enable `cpu_en` from the free-running board clock, replacing raw clock gating.
- Supports free-run at a prescaled rate, pause, single-step, halt switch and one instruction-address breakpoint.
- Sits between board inputs (KEY/SW) and the integrated processor's clock enable.
- Counts executed steps for display on the hex output groups.

Parameters:
- DIV_COUNT, 25000000: board-clock cycles per enable in RUN mode (2 Hz at 50 MHz); legal range ≥ 2.
- CNT_W, 25: prescaler counter width; must satisfy 2^CNT_W ≥ DIV_COUNT.

Ports:
- clock  input  1  board clock; all state changes on its rising edge.
- reset  input  1  synchronous reset, active-high.
- run_n  input  1  run/pause key, active-low, asynchronous to clock.
- step_n  input  1  single-step key, active-low, asynchronous to clock.
- halt  input  1  level switch; 1 forces pause.
- bp_enable  input  1  breakpoint enable.
- bp_addr  input  32  breakpoint instruction address.
- pc  input  32  current instruction address from the core.
- cpu_en  output  1  registered one-cycle core clock enable.
- state  output  2  00 IDLE, 01 RUN, 10 STEP, 11 BREAK.
- bp_hit  output  1  high while in BREAK.
- step_count  output  32  number of cpu_en pulses issued.

Behaviour:
- Reset values: state=IDLE, cpu_en=0, bp_hit=0, step_count=0, prescaler=0, skip flag=0, key synchronizer flops=1.
- Key input path: each key passes through a 2-flop synchronizer, then a previous-value flop.
- A press is the cycle where the previous value is 1 and the synchronized value is 0: one press per falling edge, no auto-repeat.
- Press detection is 3 cycles after the pin falls.
- bp_match = bp_enable & (pc == bp_addr), combinational.
- Prescaler: cleared to 0 whenever state != RUN. In RUN it increments; tick = (count == DIV_COUNT-1), and the count wraps to 0 on tick.
- Halt has priority over all other rules. While halt=1:
  - next state = IDLE; presses are ignored; cpu_en=0.
  - skip is cleared; bp_hit=0.
- IDLE:
  - run press → RUN.
  - step press → STEP.
  - run and step pressed in the same cycle → run wins.
- RUN:
  - run press → IDLE; no enable that cycle, even if tick coincides.
  - step press is ignored.
  - On tick with bp_match & !skip → BREAK, no enable.
  - On tick otherwise → cpu_en=1 next cycle and skip cleared.
- STEP:
  - cpu_en=1 in the cycle after entry, breakpoint ignored.
  - Then → IDLE; presses during STEP are ignored.
- BREAK:
  - bp_hit=1.
  - run press → RUN with skip=1, so the breakpointed instruction executes once.
  - step press → STEP.
  - Run wins on a simultaneous press.
- cpu_en is registered and never high for two consecutive cycles except RUN with DIV_COUNT=1, which is illegal.
- step_count increments by 1 in the same cycle cpu_en=1 is driven. It wraps 0xFFFFFFFF → 0.
- Reset asserted mid-RUN or mid-STEP:
  - Next edge returns all reset values.
  - A pending step is discarded.

Test Plan:
1. DIV_COUNT=4. Reset, pulse run_n low for 5 cycles, hold 40 cycles → state=01; cpu_en pulses every 4th cycle, first 4 cycles after RUN entry; step_count=9 after 36 RUN cycles.
2. From IDLE, pulse step_n low three separate times → exactly 3 single-cycle cpu_en pulses, state returns 00 each time, step_count=3; holding step_n low 20 cycles yields only 1 pulse.
3. RUN with bp_enable=1, bp_addr=0x10; drive pc=0x10 → state=11 on next tick, bp_hit=1, no cpu_en. Press run → one cpu_en despite pc=0x10. Keep pc=0x10 → BREAK again on the following tick.
4. Assert halt during RUN and during BREAK, and press run/step while halted → state=00, cpu_en=0, bp_hit=0. Release halt → still IDLE until a run press.
5. Same-cycle run and step presses in IDLE → RUN. Run press landing on the tick cycle in RUN → IDLE with no cpu_en.
6. Preload step_count near wrap via repeated steps (or force) at 0xFFFFFFFF, then step → 0x00000000. Assert reset during STEP entry → cpu_en stays 0, all outputs at reset values.
